sync_edge_multi: RTL and testbench
==================================

Name: sync_edge_multi

Overview:
Parametrised multi-channel successor to the single-bit edge detector. Per channel it provides:
- optional synchroniser chain
- consecutive-cycle debounce filter
- registered rise/fall pulses
- per-channel edge-mode mask
- sticky pending flags with clear
- aggregate interrupt

It sits between raw external/async inputs (keys, status lines) and the control FSMs/CSR block.

Parameters:
CH_NUM, 8, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (0 = input used directly, must already be synchronous)
DEB_CNT, 4, consecutive cycles a changed level must persist before acceptance (0 or 1 = no filtering)
CNT_W, $clog2(DEB_CNT+1) (min 1), debounce counter width (derived, not overridden)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
data_in  in  CH_NUM  raw level inputs
edge_mode  in  2*CH_NUM  per-channel mode, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
pend_clr  in  CH_NUM  per-channel pending clear, one-cycle strobe
flt_level  out  CH_NUM  debounced level
data_out_pos  out  CH_NUM  one-cycle rising-edge pulse on debounced level, unmasked
data_out_neg  out  CH_NUM  one-cycle falling-edge pulse on debounced level, unmasked
evt_pulse  out  CH_NUM  data_out_pos/neg gated by edge_mode
evt_pending  out  CH_NUM  sticky event flags
irq  out  1  OR of evt_pending

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. No async reset anywhere.
- Reset state: sync chain, flt_level, counters, data_out_pos, data_out_neg, evt_pulse and evt_pending all 0, so irq = 0.
- Sync chain: s[0] <= data_in, s[j] <= s[j-1]. Synchronised value sv = s[SYNC_STAGES-1], or data_in when SYNC_STAGES = 0.
- Debounce, per channel, every cycle:
  - sv == flt: cnt <= 0.
  - sv != flt and cnt == max(DEB_CNT,1)-1: flt <= sv, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - A change shorter than DEB_CNT cycles never reaches flt. Counter never exceeds DEB_CNT-1, so no wrap.
- Edge pulses are registered in the same edge as the flt update:
  - data_out_pos <= update & sv.
  - data_out_neg <= update & ~sv.
  - Each pulse lasts exactly one cycle. pos and neg are never both high in a channel.
- Latency: if data_in changes and is first sampled at edge k and then held, flt and the pulse update at edge k + SYNC_STAGES + max(DEB_CNT,1) - 1. The pulse is visible during the following cycle.
- Minimum spacing between two pulses of one channel is max(DEB_CNT,1) cycles.
- Mode masking:
  - evt_pulse[i] = (data_out_pos[i] & mode[0]) | (data_out_neg[i] & mode[1]).
  - Combinational from registered pulses and the current edge_mode.
  - flt tracking is independent of mode. A mode change affects only pulses present from that cycle on.
- Pending flags:
  - evt_pending[i] <= evt_pulse[i] | (evt_pending[i] & ~pend_clr[i]).
  - evt_pulse and pend_clr in the same cycle: set wins (event never lost).
  - Clear takes effect the next cycle.
- irq: combinational OR of the evt_pending registers.
- Input high at reset release: flt starts at 0, so a rising pulse is generated after the normal latency. This is intentional.
- Reset mid-debounce or mid-pulse: everything is cleared at that edge. In-flight counts and pulses are discarded; no pulse appears after reset for them.
- Channels are fully independent. Simultaneous events on several channels are all reported in the same cycle.

Decomposition:
- Shared package sync_edge_pkg holds:
  - mode constants EDGE_OFF = 2'b00, EDGE_RISE = 2'b01, EDGE_FALL = 2'b10, EDGE_BOTH = 2'b11
  - a clog2-with-min-1 helper function
- Sub-module sync_edge_chan covers one channel: sync chain, debounce counter, flt, pos/neg registers. Parameters are SYNC_STAGES and DEB_CNT.
- The top generates CH_NUM instances plus the mode-mask, pending and irq logic.

Test Plan:
All scenarios use defaults (CH_NUM=8, SYNC_STAGES=2, DEB_CNT=4), mode 11 on all channels unless stated.
- Clean rise: rst high 3 cycles then low with data_in = 0; set data_in[0] = 1 before edge 10 and hold -> data_out_pos[0], evt_pulse[0] high only in the cycle after edge 15; flt_level[0] = 1 from edge 15; evt_pending[0] = 1 from edge 16; irq = 1.
- Glitch reject: data_in[3] high for 3 cycles, then low -> no pulse on any output, flt_level[3] stays 0. Repeat with 4 cycles -> exactly one pos pulse, then one neg pulse 4 cycles after the pos pulse.
- Mode mask: edge_mode ch2 = 01; data_in[2] rise then fall, spaced 10 cycles -> data_out_pos[2] and data_out_neg[2] both pulse; evt_pulse[2] only on the rise. Mode 00 -> evt_pulse[2] never asserts, pending stays 0.
- Pending collision: hold pend_clr[1] = 1 in the same cycle as evt_pulse[1] -> evt_pending[1] remains 1. Pulse pend_clr[1] alone next cycle -> evt_pending[1] = 0 the following cycle, irq = 0.
- Multi-channel plus reset: data_in = 8'hFF at once -> all 8 pos pulses in the same cycle, evt_pending = 8'hFF. Assert rst 2 cycles mid-debounce of a later 8'h00 transition -> all outputs 0, no neg pulse after reset while data_in stays 0.
- Parameter corner: SYNC_STAGES=0, DEB_CNT=0; data_in[0] rises before edge k -> pos pulse in the cycle after edge k; toggling every cycle -> alternating pos/neg pulses each cycle.

Source files
------------

// File: rtl/sync_edge_pkg.sv
// Shared edge-mode encodings and sizing helper for the multi-channel edge detector.
package sync_edge_pkg;

  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  function automatic int clog2_min1(input int v);
    return ($clog2(v) < 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/sync_edge_chan.sv
// One channel: optional synchroniser, consecutive-cycle debounce, registered edge pulses.
module sync_edge_chan
  import sync_edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CNT     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic flt,
  output logic pos,
  output logic neg
);

  localparam int DEB_EFF = (DEB_CNT < 1) ? 1 : DEB_CNT;
  localparam int CNT_W   = clog2_min1(DEB_CNT + 1);

  logic             sv;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             update;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sv = din;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] s;
      always_ff @(posedge clk) begin
        if (rst) begin
          s <= '0;
        end else begin
          s[0] <= din;
          for (int j = 1; j < SYNC_STAGES; j++) s[j] <= s[j-1];
        end
      end
      assign sv = s[SYNC_STAGES-1];
    end
  endgenerate

  // Accept the new level once it has differed from flt for DEB_EFF samples in a row.
  assign last   = (cnt == CNT_W'(DEB_EFF - 1));
  assign update = (sv != flt) && last;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      flt <= 1'b0;
      pos <= 1'b0;
      neg <= 1'b0;
    end else begin
      pos <= update & sv;
      neg <= update & ~sv;
      if (sv == flt) begin
        cnt <= '0;
      end else if (last) begin
        flt <= sv;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sync_edge_multi.sv
// Multi-channel debounced edge detector with per-channel mode mask, sticky pending flags and irq.
module sync_edge_multi
  import sync_edge_pkg::*;
#(
  parameter int CH_NUM      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CNT     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH_NUM-1:0]     data_in,
  input  logic [2*CH_NUM-1:0]   edge_mode,
  input  logic [CH_NUM-1:0]     pend_clr,
  output logic [CH_NUM-1:0]     flt_level,
  output logic [CH_NUM-1:0]     data_out_pos,
  output logic [CH_NUM-1:0]     data_out_neg,
  output logic [CH_NUM-1:0]     evt_pulse,
  output logic [CH_NUM-1:0]     evt_pending,
  output logic                  irq
);

  generate
    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
      logic [1:0] mode;
      assign mode = edge_mode[2*i +: 2];

      sync_edge_chan #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_CNT    (DEB_CNT)
      ) u_chan (
        .clk(clk),
        .rst(rst),
        .din(data_in[i]),
        .flt(flt_level[i]),
        .pos(data_out_pos[i]),
        .neg(data_out_neg[i])
      );

      // Mask applies to the registered pulses with the mode seen this cycle.
      assign evt_pulse[i] = (data_out_pos[i] & |(mode & EDGE_RISE))
                          | (data_out_neg[i] & |(mode & EDGE_FALL));
    end
  endgenerate

  // Set has priority over clear so a coincident event is never dropped.
  always_ff @(posedge clk) begin
    if (rst) evt_pending <= '0;
    else     evt_pending <= evt_pulse | (evt_pending & ~pend_clr);
  end

  assign irq = |evt_pending;

endmodule

// File: tb/tb_sync_edge_multi.sv
// Randomised bench: default and zero-sync/zero-debounce instances checked against a history-window model.
module tb_sync_edge_multi;
  import sync_edge_pkg::*;

  localparam int CH = 8;
  localparam int HL = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] data_in;
  logic [2*CH-1:0] edge_mode;
  logic [CH-1:0] pend_clr;

  logic [CH-1:0] flt_a [2];
  logic [CH-1:0] pos_a [2];
  logic [CH-1:0] neg_a [2];
  logic [CH-1:0] evt_a [2];
  logic [CH-1:0] pend_a[2];
  logic          irq_a [2];

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sync_edge_multi #(.CH_NUM(CH), .SYNC_STAGES(2), .DEB_CNT(4)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .edge_mode(edge_mode), .pend_clr(pend_clr),
    .flt_level(flt_a[0]), .data_out_pos(pos_a[0]), .data_out_neg(neg_a[0]),
    .evt_pulse(evt_a[0]), .evt_pending(pend_a[0]), .irq(irq_a[0])
  );

  sync_edge_multi #(.CH_NUM(CH), .SYNC_STAGES(0), .DEB_CNT(0)) dut0 (
    .clk(clk), .rst(rst), .data_in(data_in), .edge_mode(edge_mode), .pend_clr(pend_clr),
    .flt_level(flt_a[1]), .data_out_pos(pos_a[1]), .data_out_neg(neg_a[1]),
    .evt_pulse(evt_a[1]), .evt_pending(pend_a[1]), .irq(irq_a[1])
  );

  // Model: raw sample history; flt flips once the last D used samples all differ from it.
  logic [CH-1:0] hist [HL];
  logic [CH-1:0] m_flt [2];
  logic [CH-1:0] m_pos [2];
  logic [CH-1:0] m_neg [2];
  logic [CH-1:0] m_pend[2];
  int ms[2];
  int md[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic [CH-1:0] m_evt(input int n);
    logic [CH-1:0] e;
    for (int i = 0; i < CH; i++)
      e[i] = (m_pos[n][i] & edge_mode[2*i]) | (m_neg[n][i] & edge_mode[2*i+1]);
    return e;
  endfunction

  task automatic model_step();
    logic [CH-1:0] upd, sv;
    bit all_diff;
    if (rst) begin
      for (int h = 0; h < HL; h++) hist[h] = '0;
      for (int n = 0; n < 2; n++) begin
        m_flt[n] = '0; m_pos[n] = '0; m_neg[n] = '0; m_pend[n] = '0;
      end
    end else begin
      for (int h = HL-1; h > 0; h--) hist[h] = hist[h-1];
      hist[0] = data_in;
      for (int n = 0; n < 2; n++) begin
        sv = hist[ms[n]];
        for (int i = 0; i < CH; i++) begin
          all_diff = 1'b1;
          for (int w = 0; w < md[n]; w++)
            if (hist[ms[n]+w][i] == m_flt[n][i]) all_diff = 1'b0;
          upd[i] = all_diff;
        end
        m_pend[n] = m_evt(n) | (m_pend[n] & ~pend_clr);
        m_pos[n]  = upd & sv;
        m_neg[n]  = upd & ~sv;
        m_flt[n]  = m_flt[n] ^ upd;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("flt%0d", n),  32'(flt_a[n]),  32'(m_flt[n]));
      chk($sformatf("pos%0d", n),  32'(pos_a[n]),  32'(m_pos[n]));
      chk($sformatf("neg%0d", n),  32'(neg_a[n]),  32'(m_neg[n]));
      chk($sformatf("evt%0d", n),  32'(evt_a[n]),  32'(m_evt(n)));
      chk($sformatf("pend%0d", n), 32'(pend_a[n]), 32'(m_pend[n]));
      chk($sformatf("irq%0d", n),  32'(irq_a[n]),  32'(|m_pend[n]));
    end
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  initial begin
    int lat0, lat1;
    ms[0] = 2; md[0] = 4;
    ms[1] = 0; md[1] = 1;
    rst = 1'b1; data_in = '0; pend_clr = '0; edge_mode = {CH{EDGE_BOTH}};
    @(negedge clk);
    steps(3);
    chk("rst_irq", 32'(irq_a[0]), 32'd0);
    chk("rst_flt", 32'(flt_a[0]), 32'd0);
    rst = 1'b0;
    steps(4);

    // Clean rise with latency measurement on both instances
    data_in[0] = 1'b1;
    lat0 = 99; lat1 = 99;
    for (int i = 0; i < 20; i++) begin
      step();
      if (pos_a[0][0] && lat0 == 99) lat0 = i;
      if (pos_a[1][0] && lat1 == 99) lat1 = i;
    end
    chk("lat_sync", 32'(lat0), 32'd5);
    chk("lat_raw",  32'(lat1), 32'd0);
    chk("rise_pend", 32'(pend_a[0][0]), 32'd1);

    // Glitch reject (3 cycles) then accept (4 cycles)
    data_in[3] = 1'b1; steps(3); data_in[3] = 1'b0; steps(10);
    chk("glitch_flt", 32'(flt_a[0][3]), 32'd0);
    data_in[3] = 1'b1; steps(4); data_in[3] = 1'b0; steps(12);

    // Mode mask on ch2: rise-only then off
    edge_mode[5:4] = EDGE_RISE;
    data_in[2] = 1'b1; steps(10); data_in[2] = 1'b0; steps(10);
    edge_mode[5:4] = EDGE_OFF;
    pend_clr = 8'hFF; step(); pend_clr = '0;
    data_in[2] = 1'b1; steps(10); data_in[2] = 1'b0; steps(10);
    chk("mode_off_pend", 32'(pend_a[0][2]), 32'd0);
    edge_mode = {CH{EDGE_BOTH}};

    // Pending collision on ch1: clear coincides with the pulse
    pend_clr = 8'hFF; step(); pend_clr = '0;
    data_in[1] = 1'b1; steps(6);
    pend_clr[1] = 1'b1; step();
    chk("collide", 32'(pend_a[0][1]), 32'd1);
    step(); pend_clr[1] = 1'b0; step();
    chk("clr_pend", 32'(pend_a[0][1]), 32'd0);

    // All channels at once, then reset mid-debounce of the fall
    pend_clr = 8'hFF; step(); pend_clr = '0;
    data_in = 8'h00; steps(8);
    data_in = 8'hFF; steps(8);
    chk("all_pend", 32'(pend_a[0]), 32'hFF);
    data_in = 8'h00; steps(3);
    rst = 1'b1; steps(2); rst = 1'b0;
    steps(10);
    chk("post_rst_neg", 32'(neg_a[0]), 32'd0);

    // Toggle every cycle on ch0: raw instance alternates each cycle
    for (int i = 0; i < 12; i++) begin data_in[0] = ~data_in[0]; step(); end

    // Randomised run
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(3) == 0) data_in[i] = ~data_in[i];
      pend_clr = CH'($urandom & $urandom & $urandom);
      if (c % 64 == 0) edge_mode = 16'($urandom);
      rst = ($urandom_range(199) == 0);
      step();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
